// File: rtl/ex_unit_if.sv
// Decode-to-execute-to-memory bundle for ex_unit. The unit uses the slave modport
// and whatever drives ops into it uses the master modport.
interface ex_unit_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        aluop_i;
    logic [2:0]        alusel_i;
    logic [DATA_W-1:0] reg1_i;
    logic [DATA_W-1:0] reg2_i;
    logic [4:0]        wd_i;
    logic              wreg_i;
    logic              out_valid;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic [DATA_W-1:0] wdata_o;
    logic              stallreq_o;

    modport slave (
        input  flush, in_valid, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        output in_ready, out_valid, wd_o, wreg_o, wdata_o, stallreq_o
    );

    modport master (
        output flush, in_valid, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  in_ready, out_valid, wd_o, wreg_o, wdata_o, stallreq_o
    );
endinterface

// File: rtl/ex_unit.sv
// Execute stage. Single-cycle logic, shift and arithmetic ops, plus an iterative
// shift-add unsigned multiplier that stalls the pipeline while it runs.
module ex_unit #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic     clk,
    input  logic     rst,
    ex_unit_if.slave bus
);
    localparam int SHW   = $clog2(DATA_W);
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b011;
    localparam logic [2:0] SEL_MUL   = 3'b100;

    localparam logic [7:0] OP_AND   = 8'h24;
    localparam logic [7:0] OP_OR    = 8'h25;
    localparam logic [7:0] OP_XOR   = 8'h26;
    localparam logic [7:0] OP_NOR   = 8'h27;
    localparam logic [7:0] OP_SLL   = 8'h7C;
    localparam logic [7:0] OP_SRL   = 8'h02;
    localparam logic [7:0] OP_SRA   = 8'h03;
    localparam logic [7:0] OP_ADDU  = 8'h21;
    localparam logic [7:0] OP_SUBU  = 8'h23;
    localparam logic [7:0] OP_SLT   = 8'h2A;
    localparam logic [7:0] OP_MULTU = 8'h19;

    logic [0:0]        state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        mul_wd_q, mul_wd_d;
    logic              mul_wreg_q, mul_wreg_d;

    logic [DATA_W-1:0] res_s;
    logic              res_ok_s;
    logic              is_mul_s;
    logic              accept_s;
    logic [DATA_W-1:0] acc_plus_s;
    logic [SHW-1:0]    shamt_s;

    assign shamt_s    = bus.reg1_i[SHW-1:0];
    assign is_mul_s   = (bus.alusel_i == SEL_MUL) && (bus.aluop_i == OP_MULTU);
    assign accept_s   = bus.in_valid && (state_q == ST_IDLE) && !bus.flush;
    assign acc_plus_s = acc_q + (mplier_q[0] ? mcand_q : {DATA_W{1'b0}});

    // Single-cycle result decode; any unrecognised class/subtype pair is a bubble.
    always_comb begin
        res_s    = {DATA_W{1'b0}};
        res_ok_s = 1'b0;
        case (bus.alusel_i)
            SEL_LOGIC: begin
                case (bus.aluop_i)
                    OP_AND:  begin res_s = bus.reg1_i & bus.reg2_i;    res_ok_s = 1'b1; end
                    OP_OR:   begin res_s = bus.reg1_i | bus.reg2_i;    res_ok_s = 1'b1; end
                    OP_XOR:  begin res_s = bus.reg1_i ^ bus.reg2_i;    res_ok_s = 1'b1; end
                    OP_NOR:  begin res_s = ~(bus.reg1_i | bus.reg2_i); res_ok_s = 1'b1; end
                    default: begin res_s = {DATA_W{1'b0}};             res_ok_s = 1'b0; end
                endcase
            end
            SEL_SHIFT: begin
                case (bus.aluop_i)
                    OP_SLL:  begin res_s = bus.reg2_i << shamt_s;                     res_ok_s = 1'b1; end
                    OP_SRL:  begin res_s = bus.reg2_i >> shamt_s;                     res_ok_s = 1'b1; end
                    OP_SRA:  begin res_s = DATA_W'($signed(bus.reg2_i) >>> shamt_s); res_ok_s = 1'b1; end
                    default: begin res_s = {DATA_W{1'b0}};                            res_ok_s = 1'b0; end
                endcase
            end
            SEL_ARITH: begin
                case (bus.aluop_i)
                    OP_ADDU: begin res_s = bus.reg1_i + bus.reg2_i; res_ok_s = 1'b1; end
                    OP_SUBU: begin res_s = bus.reg1_i - bus.reg2_i; res_ok_s = 1'b1; end
                    OP_SLT:  begin
                        res_s    = {{(DATA_W-1){1'b0}}, ($signed(bus.reg1_i) < $signed(bus.reg2_i))};
                        res_ok_s = 1'b1;
                    end
                    default: begin res_s = {DATA_W{1'b0}}; res_ok_s = 1'b0; end
                endcase
            end
            SEL_NOP: begin
                res_s    = {DATA_W{1'b0}};
                res_ok_s = 1'b0;
            end
            default: begin
                res_s    = {DATA_W{1'b0}};
                res_ok_s = 1'b0;
            end
        endcase
    end

    // Next-state logic: flush outranks both acceptance and multiplier completion.
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mul_wd_d    = mul_wd_q;
        mul_wreg_d  = mul_wreg_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
            wreg_d  = 1'b0;
            acc_d   = {DATA_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && is_mul_s) begin
                        state_d    = ST_MUL;
                        mcand_d    = bus.reg1_i;
                        mplier_d   = bus.reg2_i;
                        acc_d      = {DATA_W{1'b0}};
                        cnt_d      = {CNT_W{1'b0}};
                        mul_wd_d   = bus.wd_i;
                        mul_wreg_d = bus.wreg_i;
                    end else if (accept_s) begin
                        out_valid_d = 1'b1;
                        wd_d        = bus.wd_i;
                        wreg_d      = bus.wreg_i && res_ok_s;
                        wdata_d     = res_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc_d    = acc_plus_s;
                    mcand_d  = {mcand_q[DATA_W-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
                    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b1;
                        wd_d        = mul_wd_q;
                        wreg_d      = mul_wreg_q;
                        wdata_d     = acc_plus_s;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wreg_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            wd_q        <= 5'd0;
            wreg_q      <= 1'b0;
            wdata_q     <= {DATA_W{1'b0}};
            mcand_q     <= {DATA_W{1'b0}};
            mplier_q    <= {DATA_W{1'b0}};
            acc_q       <= {DATA_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            mul_wd_q    <= 5'd0;
            mul_wreg_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mul_wd_q    <= mul_wd_d;
            mul_wreg_q  <= mul_wreg_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.stallreq_o = (state_q == ST_MUL);
    assign bus.out_valid  = out_valid_q;
    assign bus.wd_o       = wd_q;
    assign bus.wreg_o     = wreg_q;
    assign bus.wdata_o    = wdata_q;
endmodule
